// File: rtl/wb_flash_block_loader_if.sv
// Bus bundle for the block loader: flash-side read master and RAM-side write master.
interface wb_flash_block_loader_if;
    logic [31:0] wbf_adr_o;
    logic        wbf_cyc_o;
    logic        wbf_stb_o;
    logic        wbf_we_o;
    logic [31:0] wbf_dat_i;
    logic        wbf_ack_i;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_ack_i;

    modport master (
        output wbf_adr_o, wbf_cyc_o, wbf_stb_o, wbf_we_o,
        input  wbf_dat_i, wbf_ack_i,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_ack_i
    );

    modport slave (
        input  wbf_adr_o, wbf_cyc_o, wbf_stb_o, wbf_we_o,
        output wbf_dat_i, wbf_ack_i,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_ack_i
    );
endinterface

// File: rtl/wb_flash_block_loader.sv
// Copies whole flash blocks into RAM through a small word FIFO, keeping a running checksum.
module wb_flash_block_loader #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT     = 100000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [23:0] src_addr_i,
    input  logic [31:0] dst_addr_i,
    input  logic [15:0] num_blocks_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] checksum_o,
    wb_flash_block_loader_if.master bus
);
    localparam int unsigned WORDS = BLOCK_BYTES / 4;
    localparam int unsigned WCW   = $clog2(WORDS + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_F_OPEN, S_F_STREAM, S_F_GAP, S_F_DRAIN, S_DONE, S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [23:0]     blk_addr;
    logic [15:0]     blks_left;
    logic [WCW-1:0]  words_acked, acked_nxt;
    logic            gap_q;
    logic [TW-1:0]   tmo_cnt;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic            m_req;
    logic [31:0]     m_adr;
    logic [31:0]     checksum;
    logic            done_q, error_q, f_stb;
    logic            f_cyc, push, pop, start_ok, last_ack, tmo_hit, stb_nxt, done_set;

    always_comb begin
        f_cyc     = (state == S_F_OPEN) || (state == S_F_STREAM);
        push      = f_cyc && bus.wbf_ack_i;
        pop       = m_req && bus.wbm_ack_i;
        start_ok  = start_i && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
        last_ack  = push && (words_acked == WCW'(WORDS - 1));
        tmo_hit   = f_cyc && !push && (tmo_cnt == TW'(TIMEOUT - 1));
        acked_nxt = words_acked + WCW'(push);
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start_ok) state_nxt = (num_blocks_i == 16'd0) ? S_DONE : S_F_OPEN;
            S_F_OPEN:   state_nxt = last_ack ? S_F_GAP : S_F_STREAM;
            S_F_STREAM: if (last_ack) state_nxt = S_F_GAP;
            S_F_GAP:
                if (gap_q) state_nxt = (blks_left == 16'd0) ? S_F_DRAIN : S_F_OPEN;
            S_F_DRAIN:
                if ((count == '0) && !m_req) state_nxt = S_DONE;
            default:    state_nxt = S_IDLE;
        endcase
        if (tmo_hit) state_nxt = S_ERROR;
    end

    // stb is registered, so it is computed from post-edge occupancy: with >= 2 free slots
    // the one read that may complete while stb is still high always has room.
    always_comb begin
        stb_nxt  = ((state_nxt == S_F_OPEN) || (state_nxt == S_F_STREAM)) &&
                   (acked_nxt < WCW'(WORDS)) && (count_nxt <= CW'(FIFO_DEPTH - 2));
        done_set = (start_ok && (num_blocks_i == 16'd0)) ||
                   ((state == S_F_DRAIN) && (state_nxt == S_DONE));
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= bus.wbf_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            blk_addr    <= '0;
            blks_left   <= '0;
            words_acked <= '0;
            gap_q       <= 1'b0;
            tmo_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            m_req       <= 1'b0;
            m_adr       <= '0;
            checksum    <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            f_stb       <= 1'b0;
        end else begin
            done_q <= done_set;
            f_stb  <= stb_nxt;
            gap_q  <= (state == S_F_GAP) && !gap_q;
            if (start_ok) begin
                blk_addr    <= src_addr_i;
                blks_left   <= num_blocks_i;
                m_adr       <= dst_addr_i;
                checksum    <= '0;
                error_q     <= 1'b0;
                words_acked <= '0;
                tmo_cnt     <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                m_req       <= 1'b0;
            end else begin
                tmo_cnt <= (!f_cyc || push) ? '0 : tmo_cnt + TW'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) begin
                    rd_ptr   <= rd_ptr + AW'(1);
                    checksum <= checksum + mem[rd_ptr];
                    m_adr    <= m_adr + 32'd4;
                end
                count <= count_nxt;
                // one idle cycle after every RAM ack falls out of re-arming only from m_req=0
                if (pop)                          m_req <= 1'b0;
                else if (!m_req && count != '0)   m_req <= 1'b1;
                words_acked <= acked_nxt;
                if (last_ack) begin
                    words_acked <= '0;
                    blks_left   <= blks_left - 16'd1;
                end
                if ((state == S_F_GAP) && (state_nxt == S_F_OPEN))
                    blk_addr <= blk_addr + 24'(BLOCK_BYTES);
                if (tmo_hit) begin
                    error_q     <= 1'b1;
                    tmo_cnt     <= '0;
                    words_acked <= '0;
                    wr_ptr      <= '0;
                    rd_ptr      <= '0;
                    count       <= '0;
                    m_req       <= 1'b0;
                end
            end
        end
    end

    assign busy_o     = (state == S_F_OPEN) || (state == S_F_STREAM) ||
                        (state == S_F_GAP)  || (state == S_F_DRAIN);
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign checksum_o = checksum;

    assign bus.wbf_adr_o = {8'h00, blk_addr};
    assign bus.wbf_cyc_o = f_cyc;
    assign bus.wbf_stb_o = f_stb;
    assign bus.wbf_we_o  = 1'b0;
    assign bus.wbm_adr_o = m_adr;
    assign bus.wbm_dat_o = m_req ? mem[rd_ptr] : '0;
    assign bus.wbm_sel_o = 4'hF;
    assign bus.wbm_cyc_o = m_req;
    assign bus.wbm_stb_o = m_req;
    assign bus.wbm_we_o  = m_req;
endmodule
